// File: rtl/arm_pkg.sv
// arm_pkg: shared encodings for the multicycle ARM-subset control core
package arm_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_IRQ    = 3'd5,
        S_HALT   = 3'd6
    } state_t;
    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;
endpackage

// File: rtl/arm_cond_check.sv
// arm_cond_check: evaluates an ARM condition field against NZCV flags
module arm_cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/arm_mc_ctrl.sv
// arm_mc_ctrl: multicycle ARM-subset control core (PC/IR/NZCV, instruction FSM, memory handshake, IRQ entry)
module arm_mc_ctrl
    import arm_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(32'h18),
    parameter int                WAIT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic [31:0]       alu_result,
    input  logic [3:0]        alu_flags,
    input  logic [31:0]       wb_data,
    output logic              reg_write,
    output logic              link_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic [1:0]        imm_src,
    output logic [1:0]        reg_src,
    output logic [3:0]        flags,
    input  logic              nIRQ,
    input  logic              irq_clr,
    output logic              irq_ack,
    output logic              bus_err,
    output logic [2:0]        state
);
    localparam int WW = $clog2(WAIT_LIMIT + 1);
    state_t            state_q, state_d, fetch_nxt;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [3:0]        flags_q, flags_d;
    logic              i_mask_q, i_mask_d, bus_err_q, bus_err_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              cond_pass, is_load, rd_pc, mem_wait, timeout;
    logic [1:0]        cls;
    arm_cond_check u_cond (.cond(ir_q[31:28]), .nzcv(flags_q), .pass(cond_pass));
    assign cls     = ir_q[27:26];
    assign is_load = ir_q[20];
    assign rd_pc   = ir_q[15:12] == 4'hF;
    // every path back to FETCH is diverted into IRQ while an unmasked request is pending
    assign fetch_nxt = (!nIRQ && !i_mask_q) ? S_IRQ : S_FETCH;
    assign mem_wait  = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    assign timeout   = mem_wait && wait_q == WW'(WAIT_LIMIT - 1);
    assign pc      = pc_q;
    assign ir      = ir_q;
    assign flags   = flags_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flags_d    = flags_q;
        bus_err_d  = bus_err_q;
        i_mask_d   = irq_clr ? 1'b0 : i_mask_q;
        wait_d     = mem_wait ? wait_q + WW'(1) : '0;
        mem_addr   = pc_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        link_write = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        imm_src    = IMM_DP;
        reg_src    = 2'b00;
        irq_ack    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = cond_pass ? S_EXEC : fetch_nxt;
            S_EXEC: begin
                state_d = fetch_nxt;
                if (cls == CLS_DP) begin
                    alu_src = ir_q[25];
                    if (ir_q[20]) flags_d = alu_flags;
                    if (ir_q[24:21] != OP_CMP) state_d = S_WB;
                end else if (cls == CLS_MEM) begin
                    alu_src = 1'b1;
                    imm_src = IMM_MEM;
                    state_d = S_MEM;
                end else if (cls == CLS_BR) begin
                    reg_src[0] = 1'b1;
                    alu_src    = 1'b1;
                    imm_src    = IMM_BR;
                    pc_d       = alu_result[ADDR_W-1:0];
                    link_write = ir_q[24];
                end
            end
            S_MEM: begin
                mem_addr   = alu_result[ADDR_W-1:0];
                mem_read   = is_load;
                mem_write  = !is_load;
                reg_src[1] = !is_load;
                if (mem_ready) state_d = is_load ? S_WB : fetch_nxt;
            end
            S_WB: begin
                reg_write  = !rd_pc;
                mem_to_reg = cls == CLS_MEM;
                if (rd_pc) pc_d = wb_data[ADDR_W-1:0];
                state_d = fetch_nxt;
            end
            S_IRQ: begin
                irq_ack    = 1'b1;
                link_write = 1'b1;
                pc_d       = IRQ_VECTOR;
                i_mask_d   = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
        if (timeout) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
        end
        if (reset) {mem_read, mem_write, reg_write, link_write, mem_to_reg, irq_ack} = '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            flags_q   <= '0;
            i_mask_q  <= 1'b0;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flags_q   <= flags_d;
            i_mask_q  <= i_mask_d;
            bus_err_q <= bus_err_d;
            wait_q    <= wait_d;
        end
    end
endmodule

// File: tb/tb_arm_mc_ctrl.sv
// tb_arm_mc_ctrl: directed scoreboard bench for arm_mc_ctrl (instruction classes, wait states, IRQ, timeout, reset)
module tb_arm_mc_ctrl;
    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SI = 3'd5, SH = 3'd6;
    logic        clk = 1'b0, reset;
    logic [31:0] pc, ir, mem_addr, mem_rdata, alu_result, wb_data;
    logic        mem_read, mem_write, mem_ready, reg_write, link_write, mem_to_reg, alu_src;
    logic [1:0]  imm_src, reg_src;
    logic [3:0]  alu_flags, flags;
    logic        nIRQ, irq_clr, irq_ack, bus_err;
    logic [2:0]  state;
    logic [5:0]  strb;
    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    arm_mc_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .ir(ir), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .alu_result(alu_result), .alu_flags(alu_flags),
        .wb_data(wb_data), .reg_write(reg_write), .link_write(link_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .imm_src(imm_src),
        .reg_src(reg_src), .flags(flags), .nIRQ(nIRQ), .irq_clr(irq_clr),
        .irq_ack(irq_ack), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;
    assign strb = {mem_read, mem_write, reg_write, link_write, mem_to_reg, irq_ack};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic obs(input string tag, input logic [31:0] v);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, v);
        end else begin
            e = sb.pop_front();
            assert (v === e.val && tag == e.tag) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h (%s)", tag, v, e.val, e.tag);
            end
        end
    endtask

    task automatic now(input string tag, input logic [31:0] o, input logic [31:0] e);
        push(tag, e);
        obs(tag, o);
    endtask

    // one clock: expected state, pc and strobes {rd,wr,rw,lw,m2r,ack} after the edge
    task automatic adv(input logic [2:0] st, input logic [31:0] p, input logic [5:0] s);
        push("state", 32'(st));
        push("pc", p);
        push("strb", 32'(s));
        cyc();
        obs("state", 32'(state));
        obs("pc", pc);
        obs("strb", 32'(strb));
    endtask

    initial begin
        reset = 1'b1; nIRQ = 1'b1; irq_clr = 1'b0; mem_ready = 1'b1; mem_rdata = '0;
        alu_result = '0; alu_flags = '0; wb_data = '0;
        cyc();
        adv(SF, 32'h0, 6'b000000);
        now("ir_rst", ir, 32'h0);
        now("flags_rst", 32'(flags), 32'h0);
        now("bus_err_rst", 32'(bus_err), 32'h0);
        reset = 1'b0;
        #1;
        now("strb_fetch", 32'(strb), 32'(6'b100000));
        now("addr_fetch0", mem_addr, 32'h0);
        // ADD R1,R2,#5
        mem_rdata = 32'hE2821005;
        adv(SD, 32'h4, 6'b000000);
        now("ir_add", ir, 32'hE2821005);
        adv(SE, 32'h4, 6'b000000);
        now("alu_src_add", 32'(alu_src), 32'h1);
        now("imm_src_add", 32'(imm_src), 32'h0);
        adv(SW, 32'h4, 6'b001000);
        adv(SF, 32'h4, 6'b100000);
        // SUBS sets Z
        mem_rdata = 32'hE2523001;
        adv(SD, 32'h8, 6'b000000);
        adv(SE, 32'h8, 6'b000000);
        alu_flags = 4'b0100;
        adv(SW, 32'h8, 6'b001000);
        now("flags_subs", 32'(flags), 32'h4);
        alu_flags = 4'b0000;
        adv(SF, 32'h8, 6'b100000);
        now("addr_fetch8", mem_addr, 32'h8);
        // BEQ taken
        mem_rdata = 32'h0A00000C;
        adv(SD, 32'hC, 6'b000000);
        adv(SE, 32'hC, 6'b000000);
        now("reg_src_b", 32'(reg_src), 32'h1);
        now("imm_src_b", 32'(imm_src), 32'h2);
        now("alu_src_b", 32'(alu_src), 32'h1);
        alu_result = 32'h40;
        adv(SF, 32'h40, 6'b100000);
        // BNE not taken: 2 cycles
        mem_rdata = 32'h1A000000;
        adv(SD, 32'h44, 6'b000000);
        adv(SF, 32'h44, 6'b100000);
        // BL to 0x100
        mem_rdata = 32'hEB000000;
        adv(SD, 32'h48, 6'b000000);
        alu_result = 32'h100;
        adv(SE, 32'h48, 6'b000100);
        adv(SF, 32'h100, 6'b100000);
        // ADD at 0x100 with IRQ raised during WB
        mem_rdata = 32'hE2821005;
        adv(SD, 32'h104, 6'b000000);
        adv(SE, 32'h104, 6'b000000);
        adv(SW, 32'h104, 6'b001000);
        nIRQ = 1'b0;
        adv(SI, 32'h104, 6'b000101);
        irq_clr = 1'b1;
        adv(SF, 32'h18, 6'b100000);
        irq_clr = 1'b0;
        // masked: second request ignored on the cond-fail retire
        mem_rdata = 32'h1A000000;
        adv(SD, 32'h1C, 6'b000000);
        adv(SF, 32'h1C, 6'b100000);
        // irq_clr unmasks; CMP then diverts into IRQ
        irq_clr = 1'b1;
        mem_rdata = 32'hE3520000;
        adv(SD, 32'h20, 6'b000000);
        irq_clr = 1'b0;
        adv(SE, 32'h20, 6'b000000);
        alu_flags = 4'b0010;
        adv(SI, 32'h20, 6'b000101);
        now("flags_cmp", 32'(flags), 32'h2);
        alu_flags = 4'b0000;
        nIRQ = 1'b1;
        adv(SF, 32'h18, 6'b100000);
        // BEQ with Z clear fails
        mem_rdata = 32'h0A000000;
        adv(SD, 32'h1C, 6'b000000);
        adv(SF, 32'h1C, 6'b100000);
        // LDR with 3 wait states in MEM
        mem_rdata = 32'hE5910000;
        adv(SD, 32'h20, 6'b000000);
        adv(SE, 32'h20, 6'b000000);
        now("alu_src_ldr", 32'(alu_src), 32'h1);
        now("imm_src_ldr", 32'(imm_src), 32'h1);
        alu_result = 32'h200;
        mem_ready = 1'b0;
        adv(SM, 32'h20, 6'b100000);
        now("addr_ldr", mem_addr, 32'h200);
        for (int i = 0; i < 3; i++) adv(SM, 32'h20, 6'b100000);
        mem_ready = 1'b1;
        adv(SW, 32'h20, 6'b001010);
        adv(SF, 32'h20, 6'b100000);
        // MOV PC,#... : writeback to R15 redirects pc
        mem_rdata = 32'hE3A0F000;
        adv(SD, 32'h24, 6'b000000);
        adv(SE, 32'h24, 6'b000000);
        wb_data = 32'h300;
        adv(SW, 32'h24, 6'b000000);
        adv(SF, 32'h300, 6'b100000);
        // STR, reset during wait
        mem_rdata = 32'hE5810000;
        adv(SD, 32'h304, 6'b000000);
        alu_result = 32'h400;
        adv(SE, 32'h304, 6'b000000);
        adv(SM, 32'h304, 6'b010000);
        now("reg_src_str", 32'(reg_src), 32'h2);
        now("addr_str", mem_addr, 32'h400);
        mem_ready = 1'b0;
        adv(SM, 32'h304, 6'b010000);
        reset = 1'b1;
        #1;
        now("strb_rst_drop", 32'(strb), 32'h0);
        adv(SF, 32'h0, 6'b000000);
        now("flags_rst2", 32'(flags), 32'h0);
        now("ir_rst2", ir, 32'h0);
        // FETCH timeout at WAIT_LIMIT=4
        reset = 1'b0;
        for (int i = 0; i < 3; i++) adv(SF, 32'h0, 6'b100000);
        now("bus_err_pre", 32'(bus_err), 32'h0);
        adv(SH, 32'h0, 6'b000000);
        now("bus_err_set", 32'(bus_err), 32'h1);
        mem_ready = 1'b1;
        adv(SH, 32'h0, 6'b000000);
        reset = 1'b1;
        adv(SF, 32'h0, 6'b000000);
        now("bus_err_clr", 32'(bus_err), 32'h0);
        reset = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
